// File: rtl/gsensor_tilt_scheduler_if.sv
// Display channel between the tilt scheduler and the HEX driver:
// the packed {x_code, y_code} word moved with a valid/ready handshake.
interface gsensor_tilt_scheduler_if;
   logic        disp_valid;
   logic        disp_ready;
   logic [15:0] disp_data;

   // The scheduler produces the word; the HEX driver accepts it.
   modport master (output disp_valid, output disp_data, input disp_ready);
   modport slave  (input disp_valid, input disp_data, output disp_ready);
endinterface

// File: rtl/gsensor_tilt_scheduler.sv
// G-sensor tilt scheduler: samples the one-hot X/Y LED bars at a fixed rate,
// decodes them into signed HEX tilt codes, debounces each axis and publishes
// the packed {x,y} code to the HEX driver only when the accepted value changes.
module gsensor_tilt_scheduler #(
   parameter int unsigned SAMPLE_DIV   = 50000,
   parameter int unsigned STABLE_COUNT = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [7:0]                      gsensor_led_x_data,
   input  logic [7:0]                      gsensor_led_y_data,
   gsensor_tilt_scheduler_if.master        disp,
   output logic                            invalid_err,
   output logic                            overrun
);

   localparam int unsigned    DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [3:0]     STABLE   = 4'(STABLE_COUNT);

   typedef enum logic [2:0] {IDLE, SAMPLE, FILTER, COMMIT, PUBLISH} state_t;

   // One decoded bar: legal flag plus the HEX tilt code.
   typedef struct packed {
      logic       legal;
      logic [7:0] code;
   } decode_t;

   // Debounce state of one axis.
   typedef struct packed {
      logic [7:0] cand;
      logic [3:0] cnt;
   } axis_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q;
   logic             tick;
   logic             pending_q;
   decode_t          x_dec_q, y_dec_q;
   axis_t            x_axis_q, y_axis_q;
   logic [7:0]       x_acc, y_acc;
   logic             change;
   logic             load_sample, run_filter, commit;

   // Bar-to-code table; anything not listed is an illegal bar.
   function automatic decode_t decode_bar(input logic [7:0] bar);
      decode_t d;
      d.legal = 1'b1;
      case (bar)
         8'h18:   d.code = 8'h00;
         8'h20:   d.code = 8'hB1;
         8'h04:   d.code = 8'hA1;
         8'h40:   d.code = 8'hB2;
         8'h02:   d.code = 8'hA2;
         8'h80:   d.code = 8'hB3;
         8'h01:   d.code = 8'hA3;
         default: begin
            d.legal = 1'b0;
            d.code  = 8'h00;
         end
      endcase
      return d;
   endfunction

   // Debounce step: an illegal sample breaks the run, a repeat extends it
   // (saturating at STABLE), a new code starts a fresh run.
   function automatic axis_t filter_axis(input axis_t cur, input decode_t smp);
      axis_t nxt;
      nxt = cur;
      if (!smp.legal) begin
         nxt.cnt = 4'd0;
      end else if (smp.code == cur.cand) begin
         if (cur.cnt < STABLE) nxt.cnt = cur.cnt + 4'd1;
      end else begin
         nxt.cand = smp.code;
         nxt.cnt  = 4'd1;
      end
      return nxt;
   endfunction

   assign tick = (div_q == DIV_LAST);

   // Free-running sample divider, wraps on the tick cycle.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset)     div_q <= '0;
      else if (tick) div_q <= '0;
      else           div_q <= div_q + DIV_W'(1);
   end

   // Ticks arriving while busy are pended once; a second one is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (state_q != IDLE) begin
            if (tick) begin
               if (pending_q) overrun   <= 1'b1;
               else           pending_q <= 1'b1;
            end
         end else if (tick || pending_q) begin
            pending_q <= 1'b0;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      case (state_q)
         IDLE:    if (tick || pending_q) state_d = SAMPLE;
         SAMPLE:  state_d = FILTER;
         FILTER:  state_d = COMMIT;
         COMMIT:  state_d = change ? PUBLISH : IDLE;
         PUBLISH: if (disp.disp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: handshake valid and datapath strobes.
   always_comb begin
      disp.disp_valid = 1'b0;
      load_sample     = 1'b0;
      run_filter      = 1'b0;
      commit          = 1'b0;
      case (state_q)
         SAMPLE:  load_sample     = 1'b1;
         FILTER:  run_filter      = 1'b1;
         COMMIT:  commit          = 1'b1;
         PUBLISH: disp.disp_valid = 1'b1;
         default: ;
      endcase
   end

   // Accepted pair: a settled axis takes its candidate, else keeps what is shown.
   always_comb begin
      x_acc  = (x_axis_q.cnt == STABLE) ? x_axis_q.cand : disp.disp_data[15:8];
      y_acc  = (y_axis_q.cnt == STABLE) ? y_axis_q.cand : disp.disp_data[7:0];
      change = ({x_acc, y_acc} != disp.disp_data);
   end

   // Sample capture, per-axis debounce and illegal-bar flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_dec_q     <= '0;
         y_dec_q     <= '0;
         x_axis_q    <= '0;
         y_axis_q    <= '0;
         invalid_err <= 1'b0;
      end else begin
         invalid_err <= 1'b0;
         if (load_sample) begin
            x_dec_q <= decode_bar(gsensor_led_x_data);
            y_dec_q <= decode_bar(gsensor_led_y_data);
         end
         if (run_filter) begin
            x_axis_q    <= filter_axis(x_axis_q, x_dec_q);
            y_axis_q    <= filter_axis(y_axis_q, y_dec_q);
            invalid_err <= !x_dec_q.legal || !y_dec_q.legal;
         end
      end
   end

   // Display word: loaded only in COMMIT when the accepted pair changed.
   always_ff @(posedge clk) begin
      if (reset)                 disp.disp_data <= 16'h0000;
      else if (commit && change) disp.disp_data <= {x_acc, y_acc};
   end

endmodule
